// File: rtl/joker_ep_in_tx.sv
// EP1 IN reply engine: buffers a reply written by the command controller and
// streams it to the USB core as MAX_PKT-sized IN packets with retry and ZLP.
module joker_ep_in_tx #(
  parameter int MAX_PKT    = 64,
  parameter int ZLP_EN     = 1,
  parameter int ACK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] usb_in_addr,
  input  logic [7:0]  usb_in_data,
  input  logic        usb_in_wren,
  input  logic        usb_in_commit,
  input  logic [10:0] usb_in_commit_len,
  output logic        usb_in_ready,
  output logic        usb_in_commit_ack,
  input  logic        in_token,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        tx_zlp,
  input  logic        tx_ready,
  input  logic        tx_ack,
  input  logic        tx_retry
);

  localparam logic [10:0] MAX_PKT_W = 11'(MAX_PKT);
  localparam logic [10:0] MOD_MASK  = 11'(MAX_PKT - 1);
  localparam int          ACW       = $clog2(ACK_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TOKEN, PREFETCH, SEND, SEND_ZLP, WAIT_HS, ACK, RELEASE
  } state_t;

  state_t state;

  // Handshake: a tx beat transfers on a clock edge where tx_valid and tx_ready
  // are both high; tx_data/tx_last/tx_zlp hold steady while tx_ready is low.

  logic [7:0]  mem [2048];
  logic [7:0]  ram_q;
  logic        rd_en;
  logic [10:0] rd_addr;

  logic [10:0] len, base, rd_ptr, remaining, pkt_len;
  logic [10:0] pkt_calc, next_base, next_idx;
  logic        commit_seen;
  logic [ACW-1:0] ack_cnt;

  assign pkt_calc  = (remaining > MAX_PKT_W) ? MAX_PKT_W : remaining;
  assign next_base = base + pkt_len;
  assign next_idx  = rd_ptr + 11'd1 - base;

  // The read port runs one byte ahead of tx_data so accepted beats stream at 1/clk.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = base;
    case (state)
      WAIT_TOKEN: rd_en = in_token && (pkt_calc != 11'd0);
      PREFETCH: begin
        rd_en   = 1'b1;
        rd_addr = rd_ptr + 11'd1;
      end
      SEND: begin
        rd_en   = tx_ready;
        rd_addr = rd_ptr + 11'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (usb_in_wren && usb_in_ready) mem[usb_in_addr] <= usb_in_data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      usb_in_ready      <= 1'b1;
      usb_in_commit_ack <= 1'b0;
      tx_valid          <= 1'b0;
      tx_last           <= 1'b0;
      tx_zlp            <= 1'b0;
      tx_data           <= 8'd0;
      len               <= 11'd0;
      base              <= 11'd0;
      rd_ptr            <= 11'd0;
      remaining         <= 11'd0;
      pkt_len           <= 11'd0;
      commit_seen       <= 1'b0;
      ack_cnt           <= '0;
    end else begin
      if (!usb_in_commit) commit_seen <= 1'b0;
      case (state)
        IDLE: begin
          if (usb_in_commit && !commit_seen) begin
            len          <= usb_in_commit_len;
            remaining    <= usb_in_commit_len;
            base         <= 11'd0;
            rd_ptr       <= 11'd0;
            commit_seen  <= 1'b1;
            usb_in_ready <= 1'b0;
            state        <= WAIT_TOKEN;
          end
        end
        WAIT_TOKEN: begin
          if (in_token) begin
            pkt_len <= pkt_calc;
            if (pkt_calc == 11'd0) begin
              tx_valid <= 1'b1;
              tx_last  <= 1'b1;
              tx_zlp   <= 1'b1;
              state    <= SEND_ZLP;
            end else begin
              rd_ptr <= base;
              state  <= PREFETCH;
            end
          end
        end
        PREFETCH: begin
          tx_data  <= ram_q;
          tx_valid <= 1'b1;
          tx_zlp   <= 1'b0;
          tx_last  <= (pkt_len == 11'd1);
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              state    <= WAIT_HS;
            end else begin
              rd_ptr  <= rd_ptr + 11'd1;
              tx_data <= ram_q;
              tx_last <= (next_idx == pkt_len - 11'd1);
            end
          end
        end
        SEND_ZLP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_zlp   <= 1'b0;
            state    <= WAIT_HS;
          end
        end
        WAIT_HS: begin
          if (tx_retry) begin
            rd_ptr <= base;
            state  <= WAIT_TOKEN;
          end else if (tx_ack) begin
            base      <= next_base;
            rd_ptr    <= next_base;
            remaining <= remaining - pkt_len;
            // A nonzero acked packet ending exactly at len owes a trailing ZLP.
            if (next_base < len) begin
              state <= WAIT_TOKEN;
            end else if (ZLP_EN != 0 && len != 11'd0 && (len & MOD_MASK) == 11'd0 &&
                         pkt_len != 11'd0) begin
              state <= WAIT_TOKEN;
            end else begin
              usb_in_commit_ack <= 1'b1;
              ack_cnt           <= '0;
              state             <= ACK;
            end
          end
        end
        ACK: begin
          if (ack_cnt == ACW'(ACK_CYCLES - 1)) begin
            usb_in_commit_ack <= 1'b0;
            state             <= RELEASE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!usb_in_commit) begin
            usb_in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joker_ep_in_tx.sv
// Directed bench for joker_ep_in_tx: a ZLP-enabled instance is checked against
// a byte model; a ZLP-disabled twin shares the stimulus for the no-ZLP case.
module tb_joker_ep_in_tx;

  logic        clk, reset;
  logic [10:0] usb_in_addr;
  logic [7:0]  usb_in_data;
  logic        usb_in_wren, usb_in_commit;
  logic [10:0] usb_in_commit_len;
  logic        usb_in_ready, usb_in_commit_ack;
  logic        in_token;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, tx_zlp;
  logic        tx_ready, tx_ack, tx_retry;

  logic        z_ready, z_ack, z_valid, z_last, z_zlp;
  logic [7:0]  z_data;

  int vectors = 0;
  int miscompares = 0;
  int z_beats = 0;
  logic [7:0] model [2048];
  logic [7:0] exp_q [$];

  joker_ep_in_tx #(.MAX_PKT(64), .ZLP_EN(1), .ACK_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .usb_in_addr(usb_in_addr), .usb_in_data(usb_in_data), .usb_in_wren(usb_in_wren),
    .usb_in_commit(usb_in_commit), .usb_in_commit_len(usb_in_commit_len),
    .usb_in_ready(usb_in_ready), .usb_in_commit_ack(usb_in_commit_ack),
    .in_token(in_token), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_zlp(tx_zlp), .tx_ready(tx_ready), .tx_ack(tx_ack), .tx_retry(tx_retry)
  );

  joker_ep_in_tx #(.MAX_PKT(64), .ZLP_EN(0), .ACK_CYCLES(4)) dut_nozlp (
    .clk(clk), .reset(reset),
    .usb_in_addr(usb_in_addr), .usb_in_data(usb_in_data), .usb_in_wren(usb_in_wren),
    .usb_in_commit(usb_in_commit), .usb_in_commit_len(usb_in_commit_len),
    .usb_in_ready(z_ready), .usb_in_commit_ack(z_ack),
    .in_token(in_token), .tx_data(z_data), .tx_valid(z_valid), .tx_last(z_last),
    .tx_zlp(z_zlp), .tx_ready(tx_ready), .tx_ack(tx_ack), .tx_retry(tx_retry)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (z_valid && tx_ready) z_beats <= z_beats + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic write_byte(input logic [10:0] a, input logic [7:0] d, input bit stored);
    usb_in_addr = a;
    usb_in_data = d;
    usb_in_wren = 1'b1;
    tick();
    usb_in_wren = 1'b0;
    if (stored) model[a] = d;
  endtask

  task automatic do_commit(input logic [10:0] n);
    usb_in_commit     = 1'b1;
    usb_in_commit_len = n;
    tick();
    check("ready_low_after_commit", usb_in_ready, 1'b0);
  endtask

  // Token, then collect beats; n==0 expects a ZLP. stop_at>0 ends after that many beats.
  task automatic get_packet(input string tag, input int start, input int n,
                            input bit toggle, input int stop_at);
    int lat, got;
    bit done, seen_first, last_exp;
    logic [7:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(model[start + i]);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    lat = 1; got = 0; done = 1'b0; seen_first = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (tx_valid) begin
        if (!seen_first) begin
          check({tag, "_latency"}, lat, (n == 0) ? 1 : 2);
          seen_first = 1'b1;
        end
        if (tx_ready) begin
          if (n == 0) begin
            check({tag, "_zlp_flag"}, tx_zlp, 1'b1);
            check({tag, "_zlp_last"}, tx_last, 1'b1);
            done = 1'b1;
          end else begin
            e = exp_q.pop_front();
            last_exp = (exp_q.size() == 0);
            check($sformatf("%s_data[%0d]", tag, got), tx_data, e);
            check($sformatf("%s_last[%0d]", tag, got), tx_last, last_exp);
            check($sformatf("%s_nozlp[%0d]", tag, got), tx_zlp, 1'b0);
            got++;
            if (last_exp || got == stop_at) done = 1'b1;
          end
        end
      end
      tick();
      lat++;
    end
    tx_ready = 1'b1;
    check({tag, "_completed"}, done, 1'b1);
    if (stop_at == 0) check({tag, "_valid_drops"}, tx_valid, 1'b0);
    exp_q.delete();
  endtask

  task automatic ack_more(input string tag);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check({tag, "_no_commit_ack"}, usb_in_commit_ack, 1'b0);
  endtask

  task automatic ack_done(input string tag);
    int width;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check({tag, "_commit_ack_rise"}, usb_in_commit_ack, 1'b1);
    width = 0;
    for (int i = 0; i < 20 && usb_in_commit_ack; i++) begin
      width++;
      tick();
    end
    check({tag, "_commit_ack_width"}, width, 4);
    check({tag, "_held_busy"}, usb_in_ready, 1'b0);
  endtask

  task automatic release_commit(input string tag);
    int waited;
    usb_in_commit = 1'b0;
    waited = 0;
    tick();
    while (!usb_in_ready && waited < 4) begin
      tick();
      waited++;
    end
    check({tag, "_ready_back"}, usb_in_ready, 1'b1);
    check({tag, "_ready_latency"}, waited, 0);
  endtask

  initial begin
    int zb;
    for (int i = 0; i < 2048; i++) model[i] = 8'h00;
    reset = 1'b1;
    usb_in_addr = '0; usb_in_data = '0; usb_in_wren = 1'b0;
    usb_in_commit = 1'b0; usb_in_commit_len = '0;
    in_token = 1'b0; tx_ready = 1'b1; tx_ack = 1'b0; tx_retry = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", usb_in_ready, 1'b1);
    check("rst_commit_ack", usb_in_commit_ack, 1'b0);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_last", tx_last, 1'b0);
    check("rst_zlp", tx_zlp, 1'b0);
    check("rst_data", tx_data, 8'h00);

    // two-byte reply
    write_byte(11'd0, 8'h0D, 1'b1);
    write_byte(11'd1, 8'h5A, 1'b1);
    do_commit(11'd2);
    get_packet("p2", 0, 2, 1'b0, 0);
    ack_done("p2");
    release_commit("p2");

    // 150-byte ramp: 64/64/22
    for (int i = 0; i < 150; i++) write_byte(11'(i), 8'(i & 8'hFF), 1'b1);
    do_commit(11'd150);
    get_packet("r150_a", 0, 64, 1'b0, 0);
    ack_more("r150_a");
    get_packet("r150_b", 64, 64, 1'b0, 0);
    ack_more("r150_b");
    get_packet("r150_c", 128, 22, 1'b0, 0);
    ack_done("r150_c");
    release_commit("r150");

    // 128 bytes: trailing ZLP only with ZLP enabled
    do_commit(11'd128);
    get_packet("r128_a", 0, 64, 1'b0, 0);
    ack_more("r128_a");
    get_packet("r128_b", 64, 64, 1'b0, 0);
    ack_more("r128_b");
    check("nozlp_done_early", z_ack, 1'b1);
    zb = z_beats;
    get_packet("r128_zlp", 0, 0, 1'b0, 0);
    check("nozlp_no_third_pkt", z_beats - zb, 0);
    ack_done("r128_zlp");
    release_commit("r128");
    check("nozlp_ready_back", z_ready, 1'b1);

    // zero-length commit: exactly one ZLP
    do_commit(11'd0);
    get_packet("len0_zlp", 0, 0, 1'b0, 0);
    ack_done("len0");
    release_commit("len0");

    // len=100: busy write dropped, retry, toggled ready, ack+retry collision
    do_commit(11'd100);
    write_byte(11'd0, 8'hFF, 1'b0);
    get_packet("r100_a", 0, 64, 1'b0, 0);
    tx_retry = 1'b1; tick(); tx_retry = 1'b0;
    get_packet("r100_retry", 0, 64, 1'b1, 0);
    tx_retry = 1'b1; tx_ack = 1'b1; tick(); tx_retry = 1'b0; tx_ack = 1'b0;
    check("r100_collide_no_ack", usb_in_commit_ack, 1'b0);
    get_packet("r100_resend", 0, 64, 1'b0, 0);
    ack_more("r100_a");
    get_packet("r100_b", 64, 36, 1'b1, 0);
    ack_done("r100_b");
    for (int i = 0; i < 8; i++) tick();
    check("r100_held_commit_busy", usb_in_ready, 1'b0);
    in_token = 1'b1; tick(); in_token = 1'b0;
    tick(); tick();
    check("r100_no_second_xfer", tx_valid, 1'b0);
    release_commit("r100");

    // reset in the middle of a packet
    do_commit(11'd64);
    get_packet("mid", 0, 64, 1'b0, 30);
    usb_in_commit = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", usb_in_ready, 1'b1);
    check("mid_rst_valid", tx_valid, 1'b0);
    write_byte(11'd0, 8'hA1, 1'b1);
    write_byte(11'd1, 8'hB2, 1'b1);
    write_byte(11'd2, 8'hC3, 1'b1);
    do_commit(11'd3);
    get_packet("post_rst", 0, 3, 1'b0, 0);
    ack_done("post_rst");
    release_commit("post_rst");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joker_ep_in_tx.md
Name: joker_ep_in_tx

Overview:
- EP1 IN reply engine on the USB side of the command path.
- The command controller writes reply bytes into a 2048x8 buffer through the usb_in_* port, then raises commit with a length.
- The block streams the stored bytes to the USB device core as IN packets of at most MAX_PKT bytes, one packet per host IN token, and retransmits on host retry.
- When the transfer completes, the block pulses commit_ack and reopens the buffer.

Parameters:
- MAX_PKT, 64, max bytes per IN packet (power of 2, 8..512).
- ZLP_EN, 1, append a zero-length packet when the length is a nonzero multiple of MAX_PKT.
- ACK_CYCLES, 4, clocks usb_in_commit_ack stays high.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- usb_in_addr  in  11  buffer write address.
- usb_in_data  in  8  buffer write data.
- usb_in_wren  in  1  write strobe; the byte is stored at clk edge.
- usb_in_commit  in  1  level request to transmit the buffer.
- usb_in_commit_len  in  11  byte count, sampled when the commit is accepted.
- usb_in_ready  out  1  buffer free: writes accepted, commit accepted.
- usb_in_commit_ack  out  1  completion pulse, ACK_CYCLES wide.
- in_token  in  1  one-clock pulse: host IN token for this endpoint.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final byte of the packet; for a ZLP, asserted with tx_valid and tx_zlp.
- tx_zlp  out  1  current beat is a zero-length packet (tx_data don't-care).
- tx_ready  in  1  core accepts the beat when tx_valid and tx_ready are both high.
- tx_ack  in  1  one-clock pulse: host ACKed the last packet.
- tx_retry  in  1  one-clock pulse: packet lost; resend the same packet.

Behaviour:
- Reset values: usb_in_ready=1, usb_in_commit_ack=0, tx_valid=0, tx_last=0, tx_zlp=0, tx_data=0.
- Reset sets the state to IDLE and discards any transfer in progress mid-packet. Buffer contents are not cleared.
- Buffer writes:
  - A write is performed only when usb_in_wren=1 and usb_in_ready=1.
  - Writes while ready=0 are dropped.
  - Synchronous write; single-port write plus registered read with 1-cycle latency.
- Registers: len (11b), base (11b, start of current packet), rd_ptr (11b), remaining (11b).
- IDLE:
  - Transition occurs when usb_in_commit=1 and commit_seen=0.
  - Actions: latch len=usb_in_commit_len, base=0; set ready=0 the next clock; go to WAIT_TOKEN.
  - commit_seen is set when a commit is accepted and cleared when usb_in_commit is sampled 0. This blocks re-triggering by a still-high commit.
- WAIT_TOKEN:
  - On in_token, set pkt_len=min(MAX_PKT, len-base).
  - If pkt_len==0, go to SEND_ZLP; otherwise issue a RAM read at base and go to PREFETCH.
  - Tokens arriving in any other state are ignored.
- PREFETCH (1 clock): go to SEND with tx_valid=1, tx_data=RAM[base]. The first byte appears 2 clocks after the token.
- SEND:
  - Each accepted beat advances rd_ptr; the next byte is prefetched so back-to-back acceptance sustains 1 byte/clock.
  - tx_last=1 on beat pkt_len-1.
  - tx_valid and tx_data hold while tx_ready=0.
  - After the last beat is accepted, go to WAIT_HS.
- SEND_ZLP: drive tx_valid=tx_last=tx_zlp=1 until accepted, then go to WAIT_HS.
- WAIT_HS:
  - On tx_retry, rd_ptr=base and go to WAIT_TOKEN; the same packet is resent.
  - On tx_ack, base=base+pkt_len (11-bit, no wrap because base<=len<=2047), then:
    - if base<len, go to WAIT_TOKEN;
    - else if ZLP_EN and len!=0 and len mod MAX_PKT==0 and the ZLP has not yet been sent, go to WAIT_TOKEN with pkt_len=0 forced;
    - else go to ACK.
  - If tx_ack and tx_retry arrive on the same clock, tx_retry wins.
- len==0 on commit: exactly one ZLP is sent; no extra ZLP follows.
- ACK: usb_in_commit_ack=1 for ACK_CYCLES clocks, then 0, then go to RELEASE.
- RELEASE:
  - Wait until usb_in_commit=0, then set ready=1 and go to IDLE.
  - The controller clears commit on the falling edge of ack, so ready returns about 2 clocks after ack falls.
- Arithmetic: all address math is 11-bit unsigned. rd_ptr never exceeds len-1 during SEND.

Test Plan:
- Write 0x0D,0x5A at addr 0,1; commit len=2; one in_token; tx_ready=1 → exactly 2 beats 0x0D then 0x5A, tx_last on the 2nd; after tx_ack, commit_ack high 4 clks; ready=1 after commit drops.
- len=150, MAX_PKT=64, ZLP_EN=1; ramp data i&0xFF → 3 packets of 64/64/22 bytes with contiguous data; no ZLP; exactly one ack pulse.
- len=128 → packets of 64 and 64, then a ZLP on the 3rd token (tx_zlp=tx_last=tx_valid=1); with ZLP_EN=0 there is no 3rd packet.
- tx_retry after packet 1 of len=100 → next token resends bytes 0..63 identically, then 64..99 follow; tx_ack and tx_retry on the same clock → resend.
- Write attempts while busy (addr 0 data 0xFF) → buffer unchanged. tx_ready toggled every other clock → data held, no byte duplicated or skipped. commit held high after ack → no second transfer.
- reset mid-SEND (byte 30 of 64) → next clock ready=1, tx_valid=0; a new commit len=3 sends 3 correct bytes.
